// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache controller.
// It sits between the MEM pipeline stage and a 64-bit-block SRAM controller.
// Each of the 64 sets holds two 64-bit lines. Each line has a valid bit and a
// 10-bit tag, and each set has one LRU bit that names the way to evict next.
module cache_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        write,
  output logic        read,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  typedef enum logic [1:0] {StIdle, StReadMiss, StWriteThru} state_t;

  state_t state_q;
  logic   read_q;
  logic   write_q;

  // Cache storage; tag and data arrays carry no reset, valid/LRU do.
  logic [63:0] data0_q [64];
  logic [63:0] data1_q [64];
  logic [9:0]  tag0_q  [64];
  logic [9:0]  tag1_q  [64];
  logic [63:0] valid0_q;
  logic [63:0] valid1_q;
  logic [63:0] lru_q;

  // Address split relative to the data-memory base.
  logic [31:0] a;
  logic        offset;
  logic [5:0]  index;
  logic [9:0]  tag;
  logic        unused_addr_bits;

  assign a      = address - BASE_ADDR;
  assign offset = a[2];
  assign index  = a[8:3];
  assign tag    = a[18:9];
  assign unused_addr_bits = ^{a[31:19], a[1:0]};

  logic        hit0;
  logic        hit1;
  logic        hit;
  logic        hit_way;
  logic [63:0] hit_line;
  logic [31:0] hit_word;
  logic        victim;
  logic        read_hit;
  logic        fill;
  logic        wr_hit;

  assign hit0     = valid0_q[index] && (tag0_q[index] == tag);
  assign hit1     = valid1_q[index] && (tag1_q[index] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_line = hit_way ? data1_q[index] : data0_q[index];
  assign hit_word = offset ? hit_line[63:32] : hit_line[31:0];

  // Fill an invalid way first, otherwise evict the way the LRU bit names.
  assign victim = !valid0_q[index] ? 1'b0 :
                  !valid1_q[index] ? 1'b1 : lru_q[index];

  assign read_hit = (state_q == StIdle) && MEM_R_EN && !MEM_W_EN && hit;
  assign fill     = (state_q == StReadMiss) && sram_ready;
  assign wr_hit   = (state_q == StWriteThru) && sram_ready && hit;

  assign sram_address = address;
  assign sram_wdata   = wdata;
  assign read         = read_q;
  assign write        = write_q;

  // Handshake to the pipeline: idle cycles complete at once unless a load misses or a store waits.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      StIdle:      ready = !(MEM_R_EN || MEM_W_EN) || (MEM_R_EN && !MEM_W_EN && hit);
      StReadMiss:  ready = sram_ready;
      StWriteThru: ready = sram_ready;
      default:     ready = 1'b0;
    endcase
  end

  // Load result: hit word in idle, the returned block's word on fill, zero otherwise.
  always_comb begin
    rdata = 32'b0;
    if (read_hit) begin
      rdata = hit_word;
    end else if (fill) begin
      rdata = offset ? sram_rdata[63:32] : sram_rdata[31:0];
    end
  end

  // Control FSM with registered SRAM request strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (MEM_W_EN) begin
            state_q <= StWriteThru;
            write_q <= 1'b1;
          end else if (MEM_R_EN && !hit) begin
            state_q <= StReadMiss;
            read_q  <= 1'b1;
          end
        end
        StReadMiss: begin
          if (sram_ready) begin
            state_q <= StIdle;
            read_q  <= 1'b0;
          end
        end
        StWriteThru: begin
          if (sram_ready) begin
            state_q <= StIdle;
            write_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
      endcase
    end
  end

  // Valid and LRU bookkeeping; LRU always points away from the way just used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      if (read_hit || wr_hit) begin
        lru_q[index] <= ~hit_way;
      end else if (fill) begin
        lru_q[index] <= ~victim;
        if (victim) begin
          valid1_q[index] <= 1'b1;
        end else begin
          valid0_q[index] <= 1'b1;
        end
      end
    end
  end

  // Tag/data arrays: whole-line fill on a read miss, single-word update on a store hit.
  always_ff @(posedge clk) begin
    if (fill) begin
      if (victim) begin
        data1_q[index] <= sram_rdata;
        tag1_q[index]  <= tag;
      end else begin
        data0_q[index] <= sram_rdata;
        tag0_q[index]  <= tag;
      end
    end else if (wr_hit) begin
      if (hit_way) begin
        if (offset) data1_q[index][63:32] <= wdata;
        else        data1_q[index][31:0]  <= wdata;
      end else begin
        if (offset) data0_q[index][63:32] <= wdata;
        else        data0_q[index][31:0]  <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a small SRAM responder driven inline.
// Expected load results are queued as each request is issued and popped when ready rises.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        write;
  logic        read;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  cache_controller #(.BASE_ADDR(32'd1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .wdata        (wdata),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .write        (write),
    .read         (read),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare rdata against the oldest queued expectation.
  task automatic pop_check(input string tag);
    logic [31:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed empty_queue expected entry", tag);
    end else begin
      exp = sb.pop_front();
      check({tag, "_rdata"}, {32'b0, rdata}, {32'b0, exp});
    end
  endtask

  // Issue a load starting just after a rising edge; a miss is serviced after a stall.
  task automatic do_read(input string tag, input logic [31:0] addr, input bit miss,
                         input logic [63:0] line, input logic [31:0] exp);
    address  = addr;
    MEM_R_EN = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    check({tag, "_ready_idle"}, {63'b0, ready}, {63'b0, !miss});
    check({tag, "_read_idle"}, {63'b0, read}, 64'd0);
    if (miss) begin
      @(negedge clk);
      check({tag, "_read_req"}, {63'b0, read}, 64'd1);
      check({tag, "_stall"}, {63'b0, ready}, 64'd0);
      check({tag, "_sram_addr"}, {32'b0, sram_address}, {32'b0, addr});
      @(negedge clk);
      sram_rdata = line;
      sram_ready = 1'b1;
      #1;
      check({tag, "_ready_fill"}, {63'b0, ready}, 64'd1);
    end
    pop_check(tag);
    @(posedge clk);
    #1;
    MEM_R_EN   = 1'b0;
    sram_ready = 1'b0;
    sram_rdata = 64'b0;
  endtask

  // Issue a write-through store with one stall cycle before the SRAM completes.
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    address  = addr;
    wdata    = data;
    MEM_W_EN = 1'b1;
    sb.push_back(32'b0);
    @(negedge clk);
    check({tag, "_ready_idle"}, {63'b0, ready}, 64'd0);
    @(negedge clk);
    check({tag, "_write_req"}, {63'b0, write}, 64'd1);
    check({tag, "_sram_wdata"}, {32'b0, sram_wdata}, {32'b0, data});
    check({tag, "_stall"}, {63'b0, ready}, 64'd0);
    @(negedge clk);
    check({tag, "_still_stall"}, {63'b0, ready}, 64'd0);
    sram_ready = 1'b1;
    #1;
    check({tag, "_ready_done"}, {63'b0, ready}, 64'd1);
    pop_check(tag);
    @(posedge clk);
    #1;
    MEM_W_EN   = 1'b0;
    sram_ready = 1'b0;
    #1;
    check({tag, "_write_drop"}, {63'b0, write}, 64'd0);
  endtask

  initial begin
    rst        = 1'b0;
    address    = 32'd0;
    wdata      = 32'd0;
    MEM_R_EN   = 1'b0;
    MEM_W_EN   = 1'b0;
    sram_rdata = 64'b0;
    sram_ready = 1'b0;
    #12;
    check("rst_ready", {63'b0, ready}, 64'd1);
    check("rst_read", {63'b0, read}, 64'd0);
    check("rst_write", {63'b0, write}, 64'd0);
    check("rst_rdata", {32'b0, rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // First fill of set 0 goes to way 0, then the neighbouring word hits.
    do_read("rd1024_miss", 32'd1024, 1'b1, 64'h00000022_00000011, 32'h11);
    do_read("rd1028_hit", 32'd1028, 1'b0, 64'b0, 32'h22);

    // Store hit updates the cached word.
    do_write("wr1024", 32'd1024, 32'hAB);
    do_read("rd1024_after_wr", 32'd1024, 1'b0, 64'b0, 32'hAB);

    // LRU: 1536 fills way 1, touching 1024 makes 1536 the victim for 2048.
    do_read("rd1536_miss", 32'd1536, 1'b1, 64'h00000044_00000033, 32'h33);
    do_read("rd1024_touch", 32'd1024, 1'b0, 64'b0, 32'hAB);
    do_read("rd2048_miss", 32'd2048, 1'b1, 64'h00000066_00000055, 32'h66 - 32'h11);
    do_read("rd1024_kept", 32'd1024, 1'b0, 64'b0, 32'hAB);
    do_read("rd2052_hit", 32'd2052, 1'b0, 64'b0, 32'h66);
    do_read("rd1536_evicted", 32'd1536, 1'b1, 64'h00000044_00000033, 32'h33);

    // Store miss does not allocate.
    do_write("wr3072", 32'd3072, 32'h77);
    do_read("rd3072_miss", 32'd3072, 1'b1, 64'h00000099_00000077, 32'h77);

    // Reset in the middle of a miss aborts it and invalidates the cache.
    address  = 32'd1040;
    MEM_R_EN = 1'b1;
    @(negedge clk);
    check("abort_idle_ready", {63'b0, ready}, 64'd0);
    @(negedge clk);
    check("abort_read_req", {63'b0, read}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_read_drop", {63'b0, read}, 64'd0);
    check("abort_rdata", {32'b0, rdata}, 64'd0);
    MEM_R_EN = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_no_reissue", {63'b0, read}, 64'd0);
    do_read("rd1040_after_rst", 32'd1040, 1'b1, 64'h000000BB_000000AA, 32'hAA);
    do_read("rd1024_after_rst", 32'd1024, 1'b1, 64'h00000022_000000CC, 32'hCC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter BASE_ADDR, 32'd1024, data-memory base; subtracted from address before tag/index/offset split.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 address  in  32  MEM-stage byte address.
REQ-005 wdata  in  32  MEM-stage store data.
REQ-006 MEM_R_EN  in  1  load request.
REQ-007 MEM_W_EN  in  1  store request.
REQ-008 rdata  out  32  load result word.
REQ-009 ready  out  1  request complete; pipeline stalls while low.
REQ-010 sram_address  out  32  address to SRAM controller, equal to address.
REQ-011 sram_wdata  out  32  store data to SRAM controller, equal to wdata.
REQ-012 write  out  1  SRAM write request.
REQ-013 read  out  1  SRAM read request.
REQ-014 sram_rdata  in  64  64-bit block returned by SRAM controller.
REQ-015 sram_ready  in  1  SRAM controller done.

Function
REQ-016 Organisation SHALL be 2-way set-associative, 64 sets, 64-bit (two-word) lines, one valid bit and 10-bit tag per way, one LRU bit per set.
REQ-017 With a = address - BASE_ADDR, offset a[2] selects word (0 = low half), index = a[8:3], tag = a[18:9].
REQ-018 Hit in way w SHALL require valid[w] and tag[w] == tag at index.
REQ-019 FSM states SHALL be IDLE, READ_MISS and WRITE_THRU, with next state registered on clk.
REQ-020 IDLE: MEM_W_EN -> WRITE_THRU; else MEM_R_EN with miss -> READ_MISS; else stay; MEM_W_EN takes priority over MEM_R_EN.
REQ-021 IDLE: ready = ~(MEM_R_EN | MEM_W_EN) | (MEM_R_EN & ~MEM_W_EN & hit), combinationally.
REQ-022 IDLE read hit: rdata = selected word of hit way in the same cycle; LRU[index] <= ~w at clock edge; no SRAM access.
REQ-023 read = 1 only in READ_MISS; write = 1 only in WRITE_THRU; both 0 in IDLE.
REQ-024 READ_MISS and WRITE_THRU: ready = sram_ready; on the sram_ready cycle, next state = IDLE.
REQ-025 READ_MISS, sram_ready cycle: rdata = sram_rdata word selected by a[2]; victim line <= sram_rdata, its tag <= tag, its valid <= 1, LRU[index] <= ~victim.
REQ-026 Victim way: way0 if invalid, else way1 if invalid, else the way given by LRU[index].
REQ-027 WRITE_THRU is write-through, no-write-allocate; on the sram_ready cycle a hit way gets the addressed word <= wdata and LRU[index] <= ~w; a miss leaves cache state unchanged.
REQ-028 MEM-side inputs SHALL be held stable by the pipeline while ready = 0; the block SHALL NOT latch them.
REQ-029 rdata SHALL be 32'b0 whenever no read hit or read fill is being returned.

Reset
REQ-030 rst = 0 SHALL immediately force state IDLE, all valid bits 0, all LRU bits 0, and read = write = 0, independent of clk.
REQ-031 Reset during READ_MISS or WRITE_THRU SHALL abort the access with no line fill, and no request is reissued after release.
REQ-032 Tag and data arrays need no reset.

Verification
REQ-033 Reset with no request -> ready = 1, read = 0, write = 0, rdata = 0; a later read of 1024 misses.
REQ-034 Read 1024 (miss) -> read = 1 with sram_address = 1024 until sram_ready with sram_rdata = 64'h00000022_00000011; that cycle ready = 1, rdata = 32'h11. Then read 1028 -> same-cycle ready, rdata = 32'h22, read stays 0.
REQ-035 After REQ-034, write 1024 with wdata = 32'hAB -> write = 1 and sram_wdata = 32'hAB; ready stays 0 until sram_ready. A following read of 1024 hits and returns 32'hAB.
REQ-036 LRU check: fill 1024 and 1536 (set 0), read 1024 again, then read 2048 (miss) -> the 1536 line is evicted. Read 1024 then hits; read 1536 then misses.
REQ-037 Write 3072 with empty cache -> SRAM write completes on sram_ready. A following read of 3072 misses (no allocate).
REQ-038 Drive rst low in READ_MISS before sram_ready -> read falls to 0 asynchronously. After release, a read of the same address misses again.
